// File: rtl/bist_pattern_gen.sv
// Multi-channel BIST stimulus generator: XNOR Fibonacci LFSR, XOR phase shifter
// and a shift/capture sequencer driving the scan chains of the circuit under test.
module bist_pattern_gen #(
  parameter int unsigned       WIDTH     = 8,
  parameter logic [WIDTH-1:0]  TAPS      = 8'h1D,
  parameter int unsigned       CHANNELS  = 1,
  parameter int unsigned       CHAIN_LEN = 8,
  parameter int unsigned       PATTERNS  = 16
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              start,
  input  logic                              seed_load,
  input  logic [WIDTH-1:0]                  seed,
  output logic [CHANNELS-1:0]               scan_in,
  output logic                              scan_enable,
  output logic                              capture,
  output logic                              busy,
  output logic                              done,
  output logic [$clog2(PATTERNS+1)-1:0]     pattern_count
);

  localparam int unsigned PCW = $clog2(PATTERNS + 1);
  localparam int unsigned CW  = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;
  localparam logic [CW-1:0]  LAST_SHIFT = CW'(CHAIN_LEN - 1);
  localparam logic [PCW-1:0] LAST_PAT   = PCW'(PATTERNS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_CAPTURE,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] lfsr_q, lfsr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [PCW-1:0]   pc_q, pc_d;
  logic             se_q, cap_q, busy_q, done_q;
  logic             feedback;

  assign feedback = ~^(lfsr_q & TAPS);

  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    cnt_d   = cnt_q;
    pc_d    = pc_q;
    unique case (state_q)
      S_IDLE: begin
        // seed_load has priority; an all-ones seed would lock the XNOR LFSR
        if (seed_load) begin
          lfsr_d = (&seed) ? '0 : seed;
        end else if (start) begin
          pc_d    = '0;
          cnt_d   = '0;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        lfsr_d = {lfsr_q[WIDTH-2:0], feedback};
        if (cnt_q == LAST_SHIFT) begin
          state_d = S_CAPTURE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_CAPTURE: begin
        pc_d = pc_q + 1'b1;
        if (pc_d == LAST_PAT) begin
          state_d = S_DONE;
        end else begin
          cnt_d   = '0;
          state_d = S_SHIFT;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Status outputs are registered from the next state so they align with it.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      lfsr_q  <= '0;
      cnt_q   <= '0;
      pc_q    <= '0;
      se_q    <= 1'b0;
      cap_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      cnt_q   <= cnt_d;
      pc_q    <= pc_d;
      se_q    <= (state_d == S_SHIFT);
      cap_q   <= (state_d == S_CAPTURE);
      busy_q  <= (state_d == S_SHIFT) || (state_d == S_CAPTURE);
      done_q  <= (state_d == S_DONE);
    end
  end

  assign scan_in[0] = lfsr_q[WIDTH-1];
  for (genvar c = 1; c < CHANNELS; c++) begin : g_phase
    assign scan_in[c] = lfsr_q[WIDTH-1] ^ lfsr_q[c-1];
  end

  assign scan_enable   = se_q;
  assign capture       = cap_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign pattern_count = pc_q;

endmodule
